// File: rtl/load_store_unit32_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit32_pkg
// Shared definitions for the load/store unit: FSM state encoding, access size
// encodings, size-to-byte-mask constants and small decode helpers.
// -----------------------------------------------------------------------------
package load_store_unit32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_INV = 2'b11;

    // Byte masks over an 8-byte window (two consecutive words).
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = MASK_B;
            SZ_H:    size_mask = MASK_H;
            SZ_W:    size_mask = MASK_W;
            default: size_mask = 8'h00;
        endcase
    endfunction

    // True when an access of this size at this byte offset spills into the
    // next word.
    function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    is_crossing = 1'b0;
            SZ_H:    is_crossing = (offset == 2'b11);
            SZ_W:    is_crossing = (offset != 2'b00);
            default: is_crossing = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit32_align.sv
// -----------------------------------------------------------------------------
// lsu_align32
// Combinational data alignment for the load/store unit.
//   Store path: shifts right-aligned store data into an 8-byte window, picks
//               the lane for the word being accessed and merges it bytewise
//               into the word currently read from memory.
//   Load path : extracts the addressed bytes from {hi,lo} and sign/zero
//               extends them to 32 bits.
// Ports:
//   size_i, unsigned_i, offset_i : latched request attributes
//   hi_word_i                    : 1 while accessing the second word
//   wdata_i                      : right-aligned store data
//   mem_word_i                   : current memory read data
//   lo_i, hi_i                   : buffered first/second read words
//   merged_o                     : word to write back
//   load_o                       : extended load result
// -----------------------------------------------------------------------------
module lsu_align32
    import load_store_unit32_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic        hi_word_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  window_s;
    logic [63:0] shifted_s;
    logic [3:0]  be_s;
    logic [31:0] lane_s;
    logic [63:0] extract_s;

    // Store path: byte enables and shifted data for the current word, then merge.
    always_comb begin
        window_s  = size_mask(size_i) << offset_i;
        shifted_s = {32'h0000_0000, wdata_i} << {offset_i, 3'b000};
        if (hi_word_i) begin
            be_s   = window_s[7:4];
            lane_s = shifted_s[63:32];
        end else begin
            be_s   = window_s[3:0];
            lane_s = shifted_s[31:0];
        end
        merged_o = mem_word_i;
        for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
                merged_o[8*b +: 8] = lane_s[8*b +: 8];
            end else begin
                merged_o[8*b +: 8] = mem_word_i[8*b +: 8];
            end
        end
    end

    // Load path: extract addressed bytes (little-endian) and extend.
    always_comb begin
        extract_s = {hi_i, lo_i} >> {offset_i, 3'b000};
        case (size_i)
            SZ_B: begin
                if (unsigned_i) begin
                    load_o = {24'h00_0000, extract_s[7:0]};
                end else begin
                    load_o = {{24{extract_s[7]}}, extract_s[7:0]};
                end
            end
            SZ_H: begin
                if (unsigned_i) begin
                    load_o = {16'h0000, extract_s[15:0]};
                end else begin
                    load_o = {{16{extract_s[15]}}, extract_s[15:0]};
                end
            end
            SZ_W:    load_o = extract_s[31:0];
            default: load_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit32.sv
// -----------------------------------------------------------------------------
// load_store_unit32
// Initiator side of a word-wide data memory. Converts byte/half/word loads and
// stores into one or two word accesses with read-modify-write merging for
// sub-word stores and sign/zero extension for loads.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_*                      : request from execute stage (valid/ready)
//   resp_valid/rdata/error     : one-cycle response
//   mem_addr, mem_write_enable,
//   mem_write_data             : word-index memory access
//   mem_read_data              : combinational read of mem_addr
// -----------------------------------------------------------------------------
module load_store_unit32
    import load_store_unit32_pkg::*;
#(
    parameter int MEM_AW           = 30,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_write_enable,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        error_q, error_d;

    logic              cross_req_s;
    logic              cross_s;
    logic [MEM_AW-1:0] word0_s;
    logic [MEM_AW-1:0] word1_s;
    logic [31:0]       merged_s;
    logic [31:0]       load_s;
    logic              hi_word_s;

    assign cross_req_s = is_crossing(req_size, req_addr[1:0]);
    assign cross_s     = is_crossing(size_q, addr_q[1:0]);
    assign word0_s     = addr_q[MEM_AW+1:2];
    // Second word wraps to 0 at the top of the word-index space.
    assign word1_s     = word0_s + MEM_AW'(1);
    assign hi_word_s   = (state_q == ST_ACC1);

    lsu_align32 u_align (
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .offset_i   (addr_q[1:0]),
        .hi_word_i  (hi_word_s),
        .wdata_i    (wdata_q),
        .mem_word_i (mem_read_data),
        .lo_i       (lo_q),
        .hi_i       (hi_q),
        .merged_o   (merged_s),
        .load_o     (load_s)
    );

    // State and request/buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            lo_q       <= 32'h0000_0000;
            hi_q       <= 32'h0000_0000;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: request capture, access sequencing and read buffering.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if ((req_size == SZ_INV) || (cross_req_s && !ALLOW_MISALIGNED)) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        error_d = 1'b0;
                        state_d = ST_ACC0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC0: begin
                lo_d = mem_read_data;
                if (cross_s) begin
                    state_d = ST_ACC1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ACC1: begin
                hi_d    = mem_read_data;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and latched request; reset returns state to
    // IDLE asynchronously so the write strobe falls without waiting for a clock.
    always_comb begin
        req_ready        = (state_q == ST_IDLE);
        resp_valid       = (state_q == ST_DONE);
        resp_error       = (state_q == ST_DONE) && error_q;
        resp_rdata       = 32'h0000_0000;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'h0000_0000;
        case (state_q)
            ST_ACC0: begin
                mem_addr         = word0_s;
                mem_write_enable = write_q;
                if (write_q) begin
                    mem_write_data = merged_s;
                end else begin
                    mem_write_data = 32'h0000_0000;
                end
            end
            ST_ACC1: begin
                mem_addr         = word1_s;
                mem_write_enable = write_q;
                if (write_q) begin
                    mem_write_data = merged_s;
                end else begin
                    mem_write_data = 32'h0000_0000;
                end
            end
            ST_DONE: begin
                if (!error_q && !write_q) begin
                    resp_rdata = load_s;
                end else begin
                    resp_rdata = 32'h0000_0000;
                end
            end
            default: begin
                resp_rdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit32.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit32
// Directed-vector bench: a zero-initialised word memory on the main instance
// and a second instance built without misaligned support.
// -----------------------------------------------------------------------------
module tb_load_store_unit32;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_error;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write_enable;
    logic [31:0]   mem_write_data, mem_read_data;

    logic          req_valid2, req_ready2, req_write2, req_unsigned2;
    logic [1:0]    req_size2;
    logic [31:0]   req_addr2, req_wdata2;
    logic          resp_valid2, resp_error2;
    logic [31:0]   resp_rdata2;
    logic [AW-1:0] mem_addr2;
    logic          mem_write_enable2;
    logic [31:0]   mem_write_data2;
    logic [31:0]   mem_read_data2;

    logic [31:0] mem_s [0:63] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem_s[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_write_enable) mem_s[mem_addr[5:0]] <= mem_write_data;
    end

    load_store_unit32 #(.MEM_AW(AW), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    load_store_unit32 #(.MEM_AW(AW), .ALLOW_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_size(req_size2), .req_unsigned(req_unsigned2), .req_addr(req_addr2),
        .req_wdata(req_wdata2), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_error(resp_error2), .mem_addr(mem_addr2),
        .mem_write_enable(mem_write_enable2), .mem_write_data(mem_write_data2),
        .mem_read_data(mem_read_data2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int wp);
        logic got;
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        @(negedge clk);
        check_val({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        wp  = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (mem_write_enable) wp++;
            @(posedge clk);
            #1 lat++;
        end
        check_val({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
        if (got) begin
            rd = resp_rdata;
            er = resp_error;
        end
        @(posedge clk);
        #1 check_val({tag, "_one_pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, wp;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_size2 = 2'b00; req_unsigned2 = 1'b0;
        req_addr2 = 32'h0; req_wdata2 = 32'h0;
        mem_read_data2 = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'h0, req_ready}, 32'h1);
        check_val("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check_val("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check_val("rst_rdata", resp_rdata, 32'h0);
        check_val("rst_we", {31'h0, mem_write_enable}, 32'h0);
        check_val("rst_addr", 32'(mem_addr), 32'h0);
        rst_n = 1'b1;

        // 1: aligned word store then load
        run_req("t1_sw", 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, rd, er, lat, wp);
        check_val("t1_sw_lat", 32'(lat), 32'd2);
        check_val("t1_sw_wp", 32'(wp), 32'd1);
        check_val("t1_sw_rdata", rd, 32'h0);
        check_val("t1_mem1", mem_s[1], 32'hDEADBEEF);
        run_req("t1_lw", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat, wp);
        check_val("t1_lw_data", rd, 32'hDEADBEEF);
        check_val("t1_lw_lat", 32'(lat), 32'd2);
        check_val("t1_lw_wp", 32'(wp), 32'd0);

        // 2: byte store merge and extended sub-word loads
        run_req("t2_sb", 1'b1, 2'b00, 1'b0, 32'h6, 32'h000000A5, rd, er, lat, wp);
        check_val("t2_mem1", mem_s[1], 32'hDEA5BEEF);
        run_req("t2_lbs", 1'b0, 2'b00, 1'b0, 32'h6, 32'h0, rd, er, lat, wp);
        check_val("t2_lb_signed", rd, 32'hFFFFFFA5);
        run_req("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, rd, er, lat, wp);
        check_val("t2_lb_unsigned", rd, 32'h000000A5);
        run_req("t2_lhs", 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, rd, er, lat, wp);
        check_val("t2_lh_signed", rd, 32'hFFFFDEA5);

        // 3: word-crossing store and load
        run_req("t3_sw", 1'b1, 2'b10, 1'b0, 32'hB, 32'h11223344, rd, er, lat, wp);
        check_val("t3_sw_wp", 32'(wp), 32'd2);
        check_val("t3_sw_lat", 32'(lat), 32'd3);
        check_val("t3_mem2", mem_s[2], 32'h44000000);
        check_val("t3_mem3", mem_s[3], 32'h00112233);
        run_req("t3_lw", 1'b0, 2'b10, 1'b0, 32'hB, 32'h0, rd, er, lat, wp);
        check_val("t3_lw_data", rd, 32'h11223344);
        check_val("t3_lw_lat", 32'(lat), 32'd3);
        // crossing half load: byte3 of word1 (DE) and byte0 of word2 (00)
        run_req("t3_lh", 1'b0, 2'b01, 1'b0, 32'h7, 32'h0, rd, er, lat, wp);
        check_val("t3_lh_data", rd, 32'h000000DE);
        check_val("t3_lh_lat", 32'(lat), 32'd3);

        // 4: invalid size, and misaligned rejection on the strict instance
        run_req("t4_inv", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat, wp);
        check_val("t4_inv_err", {31'h0, er}, 32'h1);
        check_val("t4_inv_lat", 32'(lat), 32'd1);
        check_val("t4_inv_rdata", rd, 32'h0);
        check_val("t4_inv_wp", 32'(wp), 32'd0);
        check_val("t4_mem4", mem_s[4], 32'h0);
        @(negedge clk);
        req_valid2 = 1'b1; req_write2 = 1'b0; req_size2 = 2'b10; req_addr2 = 32'h2;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        check_val("t4_mis_valid", {31'h0, resp_valid2}, 32'h1);
        check_val("t4_mis_err", {31'h0, resp_error2}, 32'h1);
        check_val("t4_mis_rdata", resp_rdata2, 32'h0);
        check_val("t4_mis_we", {31'h0, mem_write_enable2}, 32'h0);

        // 5: reset during second half of a crossing store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h1E; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_val("t5_acc0_we", {31'h0, mem_write_enable}, 32'h1);
        check_val("t5_acc0_addr", 32'(mem_addr), 32'd7);
        @(posedge clk);
        #1 check_val("t5_acc1_we", {31'h0, mem_write_enable}, 32'h1);
        check_val("t5_acc1_addr", 32'(mem_addr), 32'd8);
        rst_n = 1'b0;
        #1 check_val("t5_we_drop", {31'h0, mem_write_enable}, 32'h0);
        check_val("t5_ready_rst", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("t5_mem7", mem_s[7], 32'hF00D0000);
        check_val("t5_mem8", mem_s[8], 32'h0);
        check_val("t5_ready", {31'h0, req_ready}, 32'h1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1 if (resp_valid) seen = 1'b1;
            end
            check_val("t5_no_resp", {31'h0, seen}, 32'h0);
        end

        // 6: back-to-back requests with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h6;
        check_val("t6_ready_acc0", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1 check_val("t6_a_valid", {31'h0, resp_valid}, 32'h1);
        check_val("t6_a_data", resp_rdata, 32'hDEA5BEEF);
        check_val("t6_ready_done", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1 check_val("t6_ready_idle", {31'h0, req_ready}, 32'h1);
        check_val("t6_idle_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_val("t6_b_acc0_valid", {31'h0, resp_valid}, 32'h0);
        check_val("t6_b_acc0_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1 check_val("t6_b_valid", {31'h0, resp_valid}, 32'h1);
        check_val("t6_b_data", resp_rdata, 32'h000000A5);
        @(posedge clk);
        #1 check_val("t6_b_one_pulse", {31'h0, resp_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
